// File: rtl/key_debounce_encoder.sv
// Push-button front end: sync, debounce, press encoding, long-press auto-repeat.
// clk/rst (async, active-low); key_in raw keys; key_val code pulse; key_held level; key_long repeat flag.
module key_debounce_encoder #(
  parameter int unsigned DEBOUNCE_CYC = 1_000_000,
  parameter int unsigned LONG_CYC     = 50_000_000,
  parameter int unsigned REPEAT_CYC   = 10_000_000,
  parameter logic        KEY_ACTIVE   = 1'b0,
  parameter logic [3:0]  REPEAT_MASK  = 4'b1110
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_in,
  output logic [2:0] key_val,
  output logic [3:0] key_held,
  output logic       key_long
);

  localparam int DW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int CW = (LONG_CYC > 1) ? $clog2(LONG_CYC) : 1;

  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYC - 1);
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYC - 1);
  localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    REPEAT
  } state_e;

  logic [3:0]         sync1_q, sync1_d;
  logic [3:0]         sync2_q, sync2_d;
  logic [3:0][DW-1:0] db_cnt_q, db_cnt_d;
  logic [3:0]         held_q, held_d;
  logic [3:0]         held_prev_q, held_prev_d;
  state_e             state_q, state_d;
  logic [1:0]         key_q, key_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2:0]         val_q, val_d;
  logic               long_q, long_d;

  logic [3:0] press;
  logic [3:0] press_low;
  logic [1:0] press_idx;

  // Normalise so that 1 always means pressed.
  always_comb begin
    sync1_d = key_in ^ {4{~KEY_ACTIVE}};
    sync2_d = sync1_q;
  end

  // Counter runs only while the synced level disagrees with the accepted one.
  always_comb begin
    db_cnt_d    = db_cnt_q;
    held_d      = held_q;
    held_prev_d = held_q;
    for (int i = 0; i < 4; i++) begin
      if (sync2_q[i] == held_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DB_LAST) begin
        db_cnt_d[i] = '0;
        held_d[i]   = ~held_q[i];
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + 1'b1;
      end
    end
  end

  // Lowest-index press edge wins; isolate it as one-hot.
  always_comb begin
    press     = held_q & ~held_prev_q;
    press_low = press & (~press + 4'd1);
    press_idx = 2'd0;
    unique case (1'b1)
      press_low[0]: press_idx = 2'd0;
      press_low[1]: press_idx = 2'd1;
      press_low[2]: press_idx = 2'd2;
      press_low[3]: press_idx = 2'd3;
      default:      press_idx = 2'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    cnt_d   = cnt_q;
    val_d   = 3'd0;
    if (|press) begin
      // A new press overrides any hold/repeat in progress.
      val_d = {1'b0, press_idx} + 3'd1;
      cnt_d = '0;
      if (REPEAT_MASK[press_idx]) begin
        state_d = HOLD;
        key_d   = press_idx;
      end else begin
        state_d = IDLE;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        HOLD: begin
          if (!held_q[key_q]) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == LONG_LAST) begin
            val_d   = {1'b0, key_q} + 3'd1;
            state_d = REPEAT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        REPEAT: begin
          if (!held_q[key_q]) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == REP_LAST) begin
            val_d = {1'b0, key_q} + 3'd1;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
    long_d = (state_d == REPEAT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      db_cnt_q    <= '0;
      held_q      <= '0;
      held_prev_q <= '0;
      state_q     <= IDLE;
      key_q       <= '0;
      cnt_q       <= '0;
      val_q       <= '0;
      long_q      <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      db_cnt_q    <= db_cnt_d;
      held_q      <= held_d;
      held_prev_q <= held_prev_d;
      state_q     <= state_d;
      key_q       <= key_d;
      cnt_q       <= cnt_d;
      val_q       <= val_d;
      long_q      <= long_d;
    end
  end

  assign key_val  = val_q;
  assign key_held = held_q;
  assign key_long = long_q;

endmodule

// File: tb/tb_key_debounce_encoder.sv
// Directed bench for key_debounce_encoder.
// Small timing parameters; every cycle of each scenario checked against hand schedules.
module tb_key_debounce_encoder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] key_in = 4'hF;
  logic [2:0] key_val;
  logic [3:0] key_held;
  logic       key_long;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  key_debounce_encoder #(
    .DEBOUNCE_CYC(4),
    .LONG_CYC    (20),
    .REPEAT_CYC  (8),
    .KEY_ACTIVE  (1'b0),
    .REPEAT_MASK (4'b1110)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .key_in  (key_in),
    .key_val (key_val),
    .key_held(key_held),
    .key_long(key_long)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic vchk(input string tag, input int c, input logic [2:0] e);
    chk($sformatf("%s_val_c%0d", tag, c), 32'(key_val), 32'(e));
  endtask

  initial begin
    logic [2:0] e;

    // reset state
    step();
    step();
    chk("rst_val", 32'(key_val), 32'd0);
    chk("rst_held", 32'(key_held), 32'd0);
    chk("rst_long", 32'(key_long), 32'd0);
    rst = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      step();
      vchk("idle", c, 3'd0);
    end

    // S2 held 40 cycles: 7, +20, then every 8
    key_in = 4'b1101;
    for (int c = 1; c <= 52; c++) begin
      step();
      e = (c == 7 || c == 27 || c == 35 || c == 43) ? 3'd2 : 3'd0;
      vchk("rep", c, e);
      if (c == 20) chk("rep_held", 32'(key_held), 32'h2);
      if (c == 26) chk("rep_long26", 32'(key_long), 32'd0);
      if (c == 27) chk("rep_long27", 32'(key_long), 32'd1);
      if (c == 46) chk("rep_long46", 32'(key_long), 32'd1);
      if (c == 47) chk("rep_long47", 32'(key_long), 32'd0);
      if (c == 40) key_in = 4'hF;
    end

    // S1 held 60 cycles: masked, single pulse
    key_in = 4'b1110;
    for (int c = 1; c <= 70; c++) begin
      step();
      vchk("mask", c, (c == 7) ? 3'd1 : 3'd0);
      chk($sformatf("mask_long_c%0d", c), 32'(key_long), 32'd0);
      if (c == 60) key_in = 4'hF;
    end

    // S3 bounces every 2 cycles for 20 cycles, then stable
    for (int c = 0; c <= 45; c++) begin
      if (c > 0) begin
        step();
        vchk("bnc", c, (c == 27) ? 3'd3 : 3'd0);
      end
      if (c < 20) key_in = ((c / 2) % 2 == 0) ? 4'b1011 : 4'b1111;
      else if (c < 35) key_in = 4'b1011;
      else key_in = 4'hF;
    end

    // S2 and S4 together: lowest index wins
    key_in = 4'b0101;
    for (int c = 1; c <= 25; c++) begin
      step();
      vchk("simul", c, (c == 7) ? 3'd2 : 3'd0);
      if (c == 10) chk("simul_held", 32'(key_held), 32'hA);
      if (c == 15) key_in = 4'hF;
    end

    // S4 repeating, then S2 pressed (press wins over coinciding repeat at 43)
    key_in = 4'b0111;
    for (int c = 1; c <= 70; c++) begin
      step();
      if (c == 7 || c == 27 || c == 35) e = 3'd4;
      else if (c == 43) e = 3'd2;
      else e = 3'd0;
      vchk("abort", c, e);
      if (c == 42) chk("abort_long42", 32'(key_long), 32'd1);
      if (c == 43) chk("abort_long43", 32'(key_long), 32'd0);
      if (c == 36) key_in = 4'b0101;
      if (c == 50) key_in = 4'hF;
    end

    // S3 held, reset pulsed mid-repeat, one press after release
    key_in = 4'b1011;
    for (int c = 1; c <= 30; c++) begin
      step();
      vchk("rr", c, (c == 7 || c == 27) ? 3'd3 : 3'd0);
    end
    chk("rr_long_pre", 32'(key_long), 32'd1);
    rst = 1'b0;
    #1;
    chk("rr_async_val", 32'(key_val), 32'd0);
    chk("rr_async_held", 32'(key_held), 32'd0);
    chk("rr_async_long", 32'(key_long), 32'd0);
    for (int c = 1; c <= 3; c++) begin
      step();
      chk($sformatf("rr_in_val_c%0d", c), 32'(key_val), 32'd0);
      chk($sformatf("rr_in_long_c%0d", c), 32'(key_long), 32'd0);
    end
    rst = 1'b1;
    for (int c = 1; c <= 22; c++) begin
      step();
      vchk("rr_post", c, (c == 7) ? 3'd3 : 3'd0);
      if (c == 8) chk("rr_post_held", 32'(key_held), 32'h4);
      if (c == 10) key_in = 4'hF;
    end
    chk("final_held", 32'(key_held), 32'd0);
    chk("final_long", 32'(key_long), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
